cube_state_editor: RTL and testbench

- Writer side of the 144-bit cube_state bus consumed by the LCD renderer. Holds the 48 editable facelets (centres fixed) in registers.
- Lets the user move a cursor and cycle facelet colours using debounced buttons.
- On commit, runs a sequential 48-cycle colour-count check and flags whether the entered state has exactly 8 of each colour.
- Sits between the button debouncers and the renderer / solver input.

---
 rtl/cube_state_editor.sv | 214 +++++++++++++++++++++
 tb/tb_cube_state_editor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cube_state_editor.sv
// rtl/cube_state_editor.sv - facelet editor and colour-count validator for the cube_state bus
//
// Holds the 48 editable facelets of a cube and drives them onto the 144-bit
// cube_state bus read by the LCD renderer and the solver. Debounced buttons
// move a cursor, cycle the colour under the cursor, clear the cube, or start
// a 48-cycle check that confirms there are exactly 8 facelets of each colour.
// Centre facelets are fixed and are not carried on the bus.
//
// Ports:
//   clock        in   system clock
//   reset        in   asynchronous active-high reset
//   btn_next     in   debounced level, advance cursor (wraps 47 -> 0)
//   btn_prev     in   debounced level, move cursor back (wraps 0 -> 47)
//   btn_colour   in   debounced level, cycle colour of facelet at cursor
//   btn_clear    in   debounced level, set all facelets to unset (000)
//   btn_commit   in   debounced level, start colour-count validation
//   cube_state   out  facelet k at bits [143-3k:141-3k]
//   cursor       out  current facelet index 0..47
//   cursor_blink out  highlight phase for the renderer
//   busy         out  validation in progress (49 cycles)
//   state_valid  out  last commit passed, no edit since
//   state_error  out  last commit failed, no edit since

module cube_state_editor #(
   parameter int BLINK_DIV = 12500000
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         btn_next,
   input  logic         btn_prev,
   input  logic         btn_colour,
   input  logic         btn_clear,
   input  logic         btn_commit,
   output logic [143:0] cube_state,
   output logic [5:0]   cursor,
   output logic         cursor_blink,
   output logic         busy,
   output logic         state_valid,
   output logic         state_error
);

   localparam logic [143:0] SOLVED =
      144'h924924_6DB6DB_FFFFFF_B6DB6D_492492_DB6DB6;
   localparam int               CW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0]    BLINK_LAST = CW'(BLINK_DIV - 1);
   localparam logic [5:0]       LAST_IDX   = 6'd47;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      RESULT = 2'd2
   } fsm_t;

   fsm_t          fsm;
   logic [2:0]    facelet [48];
   logic [5:0]    count   [6];
   logic [5:0]    idx;
   logic [CW-1:0] blink_cnt;

   // One history register per button for rising-edge detection.
   logic next_q, prev_q, colour_q, clear_q, commit_q;

   logic next_e, prev_e, colour_e, clear_e, commit_e;
   logic do_clear, do_commit, do_colour, do_next, do_prev, do_move;
   logic all_eight;
   logic [2:0] cursor_colour;
   logic [2:0] check_colour;

   // Colour cycle: unset (and the unused code 001) enter at green, white wraps to green.
   function automatic logic [2:0] next_colour(input logic [2:0] c);
      logic [2:0] n;
      case (c)
         3'b010:  n = 3'b011;
         3'b011:  n = 3'b100;
         3'b100:  n = 3'b101;
         3'b101:  n = 3'b110;
         3'b110:  n = 3'b111;
         default: n = 3'b010;
      endcase
      return n;
   endfunction

   always_comb begin
      cube_state = '0;
      for (int k = 0; k < 48; k++) begin
         cube_state[143-3*k -: 3] = facelet[k];
      end
   end

   assign next_e   = btn_next   & ~next_q;
   assign prev_e   = btn_prev   & ~prev_q;
   assign colour_e = btn_colour & ~colour_q;
   assign clear_e  = btn_clear  & ~clear_q;
   assign commit_e = btn_commit & ~commit_q;

   // Only the highest-priority edge acts, and only while idle; everything
   // else in that cycle is dropped rather than queued.
   always_comb begin
      do_clear  = 1'b0;
      do_commit = 1'b0;
      do_colour = 1'b0;
      do_next   = 1'b0;
      do_prev   = 1'b0;
      if (fsm == IDLE) begin
         if (clear_e)       do_clear  = 1'b1;
         else if (commit_e) do_commit = 1'b1;
         else if (colour_e) do_colour = 1'b1;
         else if (next_e)   do_next   = 1'b1;
         else if (prev_e)   do_prev   = 1'b1;
      end
   end

   assign do_move       = do_next | do_prev;
   assign cursor_colour = facelet[cursor];
   assign check_colour  = facelet[idx];

   always_comb begin
      all_eight = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (count[c] != 6'd8) all_eight = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fsm          <= IDLE;
         for (int k = 0; k < 48; k++) begin
            facelet[k] <= SOLVED[143-3*k -: 3];
         end
         for (int c = 0; c < 6; c++) begin
            count[c] <= '0;
         end
         idx          <= '0;
         cursor       <= '0;
         blink_cnt    <= '0;
         cursor_blink <= 1'b1;
         busy         <= 1'b0;
         state_valid  <= 1'b0;
         state_error  <= 1'b0;
         next_q       <= 1'b0;
         prev_q       <= 1'b0;
         colour_q     <= 1'b0;
         clear_q      <= 1'b0;
         commit_q     <= 1'b0;
      end else begin
         // History registers follow the inputs in every state, so a button
         // held through a check does not fire when the check ends.
         next_q   <= btn_next;
         prev_q   <= btn_prev;
         colour_q <= btn_colour;
         clear_q  <= btn_clear;
         commit_q <= btn_commit;

         // A cursor move restarts the blink so the new facelet is lit at once.
         if (do_move) begin
            blink_cnt    <= '0;
            cursor_blink <= 1'b1;
         end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt    <= '0;
            cursor_blink <= ~cursor_blink;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end

         case (fsm)
            IDLE: begin
               if (do_clear) begin
                  for (int k = 0; k < 48; k++) begin
                     facelet[k] <= 3'b000;
                  end
                  state_valid <= 1'b0;
                  state_error <= 1'b0;
               end else if (do_commit) begin
                  for (int c = 0; c < 6; c++) begin
                     count[c] <= '0;
                  end
                  idx         <= '0;
                  busy        <= 1'b1;
                  state_valid <= 1'b0;
                  state_error <= 1'b0;
                  fsm         <= CHECK;
               end else if (do_colour) begin
                  facelet[cursor] <= next_colour(cursor_colour);
                  state_valid     <= 1'b0;
                  state_error     <= 1'b0;
               end else if (do_next) begin
                  cursor <= (cursor == LAST_IDX) ? 6'd0 : cursor + 6'd1;
               end else if (do_prev) begin
                  cursor <= (cursor == 6'd0) ? LAST_IDX : cursor - 6'd1;
               end
            end

            CHECK: begin
               // Codes 010..111 map to counters 0..5; unset counts nothing.
               for (int c = 0; c < 6; c++) begin
                  if (check_colour == 3'(c + 2)) count[c] <= count[c] + 6'd1;
               end
               idx <= idx + 6'd1;
               if (idx == LAST_IDX) fsm <= RESULT;
            end

            RESULT: begin
               state_valid <= all_eight;
               state_error <= ~all_eight;
               busy        <= 1'b0;
               fsm         <= IDLE;
            end

            default: fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cube_state_editor.sv
// tb/tb_cube_state_editor.sv - self-checking bench for cube_state_editor

module tb_cube_state_editor;

   localparam logic [143:0] SOLVED =
      144'h924924_6DB6DB_FFFFFF_B6DB6D_492492_DB6DB6;

   logic         clock = 1'b0;
   logic         reset;
   logic         btn_next, btn_prev, btn_colour, btn_clear, btn_commit;
   logic [143:0] cube_state;
   logic [5:0]   cursor;
   logic         cursor_blink, busy, state_valid, state_error;

   int errors = 0;
   int checks = 0;

   // Button mask bits: [4] clear, [3] commit, [2] colour, [1] next, [0] prev
   typedef struct {
      logic [4:0] btn;
      logic [5:0] cur;
      logic [2:0] col;
      logic       moved;
   } vec_t;

   vec_t tbl [13];
   vec_t exp_q [$];

   cube_state_editor #(.BLINK_DIV(6)) dut (
      .clock        (clock),
      .reset        (reset),
      .btn_next     (btn_next),
      .btn_prev     (btn_prev),
      .btn_colour   (btn_colour),
      .btn_clear    (btn_clear),
      .btn_commit   (btn_commit),
      .cube_state   (cube_state),
      .cursor       (cursor),
      .cursor_blink (cursor_blink),
      .busy         (busy),
      .state_valid  (state_valid),
      .state_error  (state_error)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [2:0] face_at(input logic [143:0] cs, input int k);
      return cs[143-3*k -: 3];
   endfunction

   task automatic drive(input logic [4:0] m);
      btn_clear  = m[4];
      btn_commit = m[3];
      btn_colour = m[2];
      btn_next   = m[1];
      btn_prev   = m[0];
   endtask

   // Rising edge on one negedge, release on the next; outputs are sampled there.
   task automatic press(input logic [4:0] m);
      @(negedge clock);
      drive(m);
      @(negedge clock);
      drive(5'b0);
   endtask

   task automatic run_commit(output int cycles);
      press(5'b01000);
      cycles = 0;
      while (busy === 1'b1 && cycles < 200) begin
         cycles++;
         @(negedge clock);
      end
   endtask

   initial begin
      int   cyc;
      vec_t e;
      logic [5:0] model_cur;

      tbl[0]  = '{5'b00001, 6'd47, 3'b110, 1'b1};
      tbl[1]  = '{5'b00010, 6'd0,  3'b101, 1'b1};
      tbl[2]  = '{5'b00010, 6'd1,  3'b100, 1'b1};
      tbl[3]  = '{5'b00100, 6'd1,  3'b101, 1'b0};
      tbl[4]  = '{5'b00100, 6'd1,  3'b110, 1'b0};
      tbl[5]  = '{5'b00100, 6'd1,  3'b111, 1'b0};
      tbl[6]  = '{5'b00100, 6'd1,  3'b010, 1'b0};
      tbl[7]  = '{5'b00001, 6'd0,  3'b101, 1'b1};
      tbl[8]  = '{5'b00001, 6'd47, 3'b110, 1'b1};
      tbl[9]  = '{5'b00011, 6'd0,  3'b101, 1'b1};
      tbl[10] = '{5'b00110, 6'd0,  3'b110, 1'b0};
      tbl[11] = '{5'b00101, 6'd0,  3'b111, 1'b0};
      tbl[12] = '{5'b00001, 6'd47, 3'b110, 1'b1};

      reset = 1'b1;
      drive(5'b0);
      repeat (2) @(negedge clock);
      reset = 1'b0;

      chk("reset_cube", cube_state, SOLVED);
      chk("reset_cursor", 144'(cursor), 144'd0);
      chk("reset_blink", 144'(cursor_blink), 144'd1);
      chk("reset_busy", 144'(busy), 144'd0);
      chk("reset_valid", 144'(state_valid), 144'd0);
      chk("reset_error", 144'(state_error), 144'd0);

      repeat (5) @(negedge clock);
      chk("blink_hold", 144'(cursor_blink), 144'd1);
      @(negedge clock);
      chk("blink_toggle", 144'(cursor_blink), 144'd0);

      run_commit(cyc);
      chk("solved_busy_len", 144'(cyc), 144'd49);
      chk("solved_valid", 144'(state_valid), 144'd1);
      chk("solved_error", 144'(state_error), 144'd0);
      chk("solved_cube", cube_state, SOLVED);

      press(5'b00100);
      chk("edit_col0", 144'(face_at(cube_state, 0)), 144'b101);
      chk("edit_clears_valid", 144'(state_valid), 144'd0);
      @(negedge clock);
      run_commit(cyc);
      chk("edit_busy_len", 144'(cyc), 144'd49);
      chk("edit_error", 144'(state_error), 144'd1);
      chk("edit_valid", 144'(state_valid), 144'd0);

      foreach (tbl[i]) begin
         exp_q.push_back(tbl[i]);
         press(tbl[i].btn);
         e = exp_q.pop_front();
         chk($sformatf("vec%0d_cursor", i), 144'(cursor), 144'(e.cur));
         chk($sformatf("vec%0d_colour", i), 144'(face_at(cube_state, int'(e.cur))), 144'(e.col));
         if (e.moved) chk($sformatf("vec%0d_blink", i), 144'(cursor_blink), 144'd1);
         @(negedge clock);
      end

      model_cur = 6'd47;
      for (int n = 0; n < 48; n++) begin
         model_cur = (model_cur == 6'd47) ? 6'd0 : model_cur + 6'd1;
         exp_q.push_back('{5'b00010, model_cur, 3'b000, 1'b1});
         press(5'b00010);
         e = exp_q.pop_front();
         if (cursor !== e.cur || cursor_blink !== 1'b1) begin
            chk($sformatf("walk%0d_cursor", n), 144'(cursor), 144'(e.cur));
            chk($sformatf("walk%0d_blink", n), 144'(cursor_blink), 144'd1);
         end
      end
      chk("walk_end_cursor", 144'(cursor), 144'd47);

      press(5'b10010);
      chk("clear_cube", cube_state, 144'd0);
      chk("clear_cursor", 144'(cursor), 144'd47);
      @(negedge clock);
      run_commit(cyc);
      chk("clear_error", 144'(state_error), 144'd1);
      chk("clear_valid", 144'(state_valid), 144'd0);

      press(5'b01000);
      repeat (5) @(negedge clock);
      btn_colour = 1'b1;
      cyc = 0;
      while (busy === 1'b1 && cyc < 200) begin
         cyc++;
         @(negedge clock);
      end
      chk("check_busy_bound", 144'(cyc < 200), 144'd1);
      repeat (3) @(negedge clock);
      chk("held_cube", cube_state, 144'd0);
      chk("held_error", 144'(state_error), 144'd1);
      btn_colour = 1'b0;
      @(negedge clock);
      chk("released_cube", cube_state, 144'd0);
      press(5'b00100);
      chk("post_check_colour", 144'(face_at(cube_state, 47)), 144'b010);
      @(negedge clock);

      press(5'b00001);
      chk("pre_reset_cursor", 144'(cursor), 144'd46);
      @(negedge clock);
      press(5'b01000);
      repeat (19) @(negedge clock);
      chk("mid_check_busy", 144'(busy), 144'd1);
      #2 reset = 1'b1;
      #1;
      chk("async_busy", 144'(busy), 144'd0);
      chk("async_cube", cube_state, SOLVED);
      chk("async_cursor", 144'(cursor), 144'd0);
      chk("async_valid", 144'(state_valid), 144'd0);
      chk("async_blink", 144'(cursor_blink), 144'd1);
      @(negedge clock);
      reset = 1'b0;
      repeat (60) @(negedge clock);
      chk("after_reset_busy", 144'(busy), 144'd0);
      chk("after_reset_error", 144'(state_error), 144'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
